// File: rtl/text_buffer.sv
// Character buffer between the CPU write path and the text engine read path.
// It supports addressed and stream writes, runs multi-cycle clear and scroll engines, and has an always-live display read port.
module text_buffer #(
    parameter int                 COLS        = 16,
    parameter int                 ROWS        = 4,
    parameter int                 CHAR_W      = 8,
    parameter logic [CHAR_W-1:0]  FILL_CHAR   = '0,
    parameter bit                 AUTO_SCROLL = 1'b1,
    localparam int                DEPTH       = COLS * ROWS,
    localparam int                AW          = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              wr_mode,
    input  logic [AW-1:0]     wr_index,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic              cmd_clear,
    input  logic              cmd_scroll,
    output logic              busy,
    output logic [AW-1:0]     cursor,
    input  logic [AW-1:0]     rd_addr,
    output logic [CHAR_W-1:0] rd_char
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [AW-1:0]     LAST_CELL  = AW'(DEPTH - 1);
    localparam logic [AW-1:0]     SCROLL_LIM = AW'(DEPTH - COLS);
    localparam logic [AW-1:0]     COLS_AW    = AW'(COLS);
    localparam logic [AW:0]       DEPTH_EXT  = (AW+1)'(DEPTH);
    localparam logic [RW-1:0]     LAST_ROW   = RW'(ROWS - 1);
    localparam logic [CW-1:0]     LAST_COL   = CW'(COLS - 1);
    localparam logic [CHAR_W-1:0] CH_CR      = CHAR_W'(8'h0D);
    localparam logic [CHAR_W-1:0] CH_LF      = CHAR_W'(8'h0A);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCROLL
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [CHAR_W-1:0] rd_char_q;

    logic [CHAR_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [CHAR_W-1:0] mem_wdata;
    logic              overflow;
    logic [AW-1:0]     scroll_src;

    // The cursor is kept as row/column so row ends need no division.
    assign cursor     = AW'(row_q) * COLS_AW + AW'(col_q);
    assign wr_ready   = (state_q == ST_IDLE);
    assign busy       = !wr_ready;
    assign rd_char    = rd_char_q;
    assign scroll_src = cnt_q + COLS_AW;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = FILL_CHAR;
        overflow  = 1'b0;

        case (state_q)
            ST_CLEAR, ST_SCROLL: begin
                mem_we = 1'b1;
                if (state_q == ST_SCROLL && cnt_q < SCROLL_LIM) begin
                    mem_wdata = mem[scroll_src];
                end
                if (cnt_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                if (cmd_clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else if (cmd_scroll) begin
                    state_d = ST_SCROLL;
                    cnt_d   = '0;
                    if (row_q != '0) begin
                        row_d = row_q - RW'(1);
                    end
                end else if (wr_valid) begin
                    if (!wr_mode) begin
                        mem_we    = ({1'b0, wr_index} < DEPTH_EXT);
                        mem_waddr = wr_index;
                        mem_wdata = wr_char;
                    end else if (wr_char == CH_CR) begin
                        col_d = '0;
                    end else if (wr_char == CH_LF) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            overflow = 1'b1;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = cursor;
                        mem_wdata = wr_char;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            if (row_q == LAST_ROW) begin
                                overflow = 1'b1;
                            end else begin
                                row_d = row_q + RW'(1);
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                    // The character that overflowed is stored above, before the scroll begins.
                    if (overflow) begin
                        col_d = '0;
                        if (AUTO_SCROLL) begin
                            row_d   = LAST_ROW;
                            state_d = ST_SCROLL;
                            cnt_d   = '0;
                        end else begin
                            row_d = '0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_char_q <= '0;
        end else if ({1'b0, rd_addr} < DEPTH_EXT) begin
            rd_char_q <= mem[rd_addr];
        end else begin
            rd_char_q <= '0;
        end
    end

endmodule

// File: tb/tb_text_buffer.sv
// Directed and randomized checks of text_buffer against a queue-free array model.
// Two instances are driven together: 16x4 with auto-scroll, and 10x5 with wrap and a non-zero fill.
module tb_text_buffer;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid = 1'b0;
    logic          wr_mode = 1'b0;
    logic          cmd_clear = 1'b0;
    logic          cmd_scroll = 1'b0;
    logic [AW-1:0] wr_index = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    wr_char = '0;

    logic          wr_ready_a, busy_a, wr_ready_b, busy_b;
    logic [AW-1:0] cursor_a, cursor_b;
    logic [7:0]    rd_char_a, rd_char_b;

    always #5 clk = ~clk;

    text_buffer #(.COLS(16), .ROWS(4), .CHAR_W(8), .FILL_CHAR(8'h00), .AUTO_SCROLL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_mode(wr_mode),
        .wr_index(wr_index), .wr_char(wr_char), .cmd_clear(cmd_clear), .cmd_scroll(cmd_scroll),
        .busy(busy_a), .cursor(cursor_a), .rd_addr(rd_addr), .rd_char(rd_char_a));

    text_buffer #(.COLS(10), .ROWS(5), .CHAR_W(8), .FILL_CHAR(8'h20), .AUTO_SCROLL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_mode(wr_mode),
        .wr_index(wr_index), .wr_char(wr_char), .cmd_clear(cmd_clear), .cmd_scroll(cmd_scroll),
        .busy(busy_b), .cursor(cursor_b), .rd_addr(rd_addr), .rd_char(rd_char_b));

    // Model: whole-buffer effects happen at once; busy is a countdown of remaining engine cycles.
    int         m_cols [2] = '{16, 10};
    int         m_rows [2] = '{4, 5};
    bit         m_auto [2] = '{1'b1, 1'b0};
    logic [7:0] m_fill [2] = '{8'h00, 8'h20};
    logic [7:0] m_mem  [2][64];
    int         m_cur  [2];
    int         m_busy [2];

    int vectors = 0;
    int miscompares = 0;

    function automatic int depth(int k);
        return m_cols[k] * m_rows[k];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_fill_all(int k);
        for (int i = 0; i < depth(k); i++) m_mem[k][i] = m_fill[k];
    endtask

    task automatic m_scroll(int k);
        for (int r = 0; r < m_rows[k]; r++)
            for (int c = 0; c < m_cols[k]; c++)
                m_mem[k][r*m_cols[k] + c] = (r == m_rows[k]-1) ? m_fill[k] : m_mem[k][(r+1)*m_cols[k] + c];
    endtask

    task automatic m_reset(int k);
        m_fill_all(k);
        m_cur[k]  = 0;
        m_busy[k] = depth(k);
    endtask

    task automatic m_overflow(int k);
        if (m_auto[k]) begin
            m_cur[k] = (m_rows[k]-1) * m_cols[k];
            m_scroll(k);
            m_busy[k] = depth(k);
        end else begin
            m_cur[k] = 0;
        end
    endtask

    task automatic m_edge(int k);
        int d;
        int c;
        d = depth(k);
        c = m_cols[k];
        if (m_busy[k] > 0) m_busy[k]--;
        else if (cmd_clear) begin
            m_fill_all(k);
            m_cur[k]  = 0;
            m_busy[k] = d;
        end else if (cmd_scroll) begin
            m_scroll(k);
            if (m_cur[k] >= c) m_cur[k] -= c;
            m_busy[k] = d;
        end else if (wr_valid) begin
            if (!wr_mode) begin
                if (int'(wr_index) < d) m_mem[k][wr_index] = wr_char;
            end else if (wr_char == 8'h0D) begin
                m_cur[k] = (m_cur[k] / c) * c;
            end else if (wr_char == 8'h0A) begin
                if (m_cur[k] / c == m_rows[k]-1) m_overflow(k);
                else m_cur[k] = (m_cur[k] / c + 1) * c;
            end else begin
                m_mem[k][m_cur[k]] = wr_char;
                if (m_cur[k] == d-1) m_overflow(k);
                else m_cur[k]++;
            end
        end
    endtask

    task automatic check_state();
        check("ready_a", 32'(wr_ready_a), 32'(m_busy[0] == 0));
        check("busy_a", 32'(busy_a), 32'(m_busy[0] != 0));
        check("cursor_a", 32'(cursor_a), 32'(m_cur[0]));
        check("ready_b", 32'(wr_ready_b), 32'(m_busy[1] == 0));
        check("busy_b", 32'(busy_b), 32'(m_busy[1] != 0));
        check("cursor_b", 32'(cursor_b), 32'(m_cur[1]));
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_busy_a"}, 32'(busy_a), 32'd1);
        check({tag, "_ready_a"}, 32'(wr_ready_a), 32'd0);
        check({tag, "_cursor_a"}, 32'(cursor_a), 32'd0);
        check({tag, "_rd_a"}, 32'(rd_char_a), 32'd0);
        check({tag, "_busy_b"}, 32'(busy_b), 32'd1);
        check({tag, "_rd_b"}, 32'(rd_char_b), 32'd0);
    endtask

    // One clock: predict read data from pre-edge contents, advance the model, compare after the edge.
    task automatic step();
        logic [7:0] rde [2];
        bit         rdv [2];
        for (int k = 0; k < 2; k++) begin
            rdv[k] = (m_busy[k] == 0);
            rde[k] = (int'(rd_addr) < depth(k)) ? m_mem[k][rd_addr] : 8'h00;
            m_edge(k);
        end
        @(posedge clk);
        #1;
        check_state();
        if (rdv[0]) check("rd_a", 32'(rd_char_a), 32'(rde[0]));
        if (rdv[1]) check("rd_b", 32'(rd_char_b), 32'(rde[1]));
    endtask

    task automatic send(bit mode, logic [7:0] ch, logic [AW-1:0] idx);
        wr_valid = 1'b1;
        wr_mode  = mode;
        wr_char  = ch;
        wr_index = idx;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic probe(logic [AW-1:0] addr);
        rd_addr = addr;
        step();
    endtask

    task automatic count_busy_a(output int n);
        n = 0;
        while (busy_a && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 500) begin
            n++;
            step();
        end
        check("idle_timeout", 32'(busy_a | busy_b), 32'd0);
    endtask

    task automatic do_reset();
        int n;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        m_reset(0);
        m_reset(1);
        check_state();
        count_busy_a(n);
        check("reset_busy_cycles", 32'(n), 32'd64);
    endtask

    initial begin
        int n;
        string s;

        // Power-on reset and sweep of the freshly cleared buffer.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_por");
        do_reset();
        wait_idle();
        for (int a = 0; a < 64; a++) begin
            probe(AW'(a));
            check("sweep_zero_a", 32'(rd_char_a), 32'd0);
        end
        check("cursor_after_reset", 32'(cursor_a), 32'd0);

        // Addressed writes; index 60 is past the end of the 50-cell instance.
        send(1'b0, 8'h41, 6'd5);
        send(1'b0, 8'h42, 6'd60);
        probe(6'd5);
        check("addr_cell5_a", 32'(rd_char_a), 32'h41);
        probe(6'd60);
        check("addr_oob_b", 32'(rd_char_b), 32'h00);
        check("addr_ready_a", 32'(wr_ready_a), 32'd1);

        // Stream with carriage return and line feed.
        s = "AB";
        send(1'b1, s[0], '0);
        send(1'b1, s[1], '0);
        send(1'b1, 8'h0D, '0);
        send(1'b1, 8'h43, '0);
        send(1'b1, 8'h0A, '0);
        send(1'b1, 8'h44, '0);
        check("stream_cursor_a", 32'(cursor_a), 32'd17);
        check("stream_cursor_b", 32'(cursor_b), 32'd11);
        probe(6'd0);
        check("stream_cell0_a", 32'(rd_char_a), 32'h43);
        probe(6'd1);
        check("stream_cell1_a", 32'(rd_char_a), 32'h42);
        probe(6'd16);
        check("stream_cell16_a", 32'(rd_char_a), 32'h44);
        probe(6'd10);
        check("stream_cell10_b", 32'(rd_char_b), 32'h44);

        // Full-buffer stream: auto-scroll on one instance, wrap on the other.
        cmd_clear = 1'b1;
        step();
        cmd_clear = 1'b0;
        wait_idle();
        for (int i = 0; i < 64; i++) send(1'b1, 8'(8'h30 + i), '0);
        count_busy_a(n);
        check("autoscroll_busy_cycles", 32'(n), 32'd64);
        check("autoscroll_cursor_a", 32'(cursor_a), 32'd48);
        check("wrap_cursor_b", 32'(cursor_b), 32'd14);
        wait_idle();
        for (int a = 0; a < 64; a++) begin
            probe(AW'(a));
            check("autoscroll_cell_a", 32'(rd_char_a), (a < 48) ? 32'(8'h40 + a) : 32'd0);
        end

        // Same-cycle clear, scroll and write: only the clear takes effect.
        cmd_clear  = 1'b1;
        cmd_scroll = 1'b1;
        wr_valid   = 1'b1;
        wr_mode    = 1'b0;
        wr_index   = 6'd3;
        wr_char    = 8'h55;
        step();
        cmd_clear  = 1'b0;
        cmd_scroll = 1'b0;
        wr_valid   = 1'b0;
        check("prio_cursor_a", 32'(cursor_a), 32'd0);
        check("prio_busy_a", 32'(busy_a), 32'd1);
        for (int i = 0; i < 10; i++) step();
        cmd_scroll = 1'b1;
        step();
        cmd_scroll = 1'b0;
        count_busy_a(n);
        check("prio_clear_busy_cycles", 32'(11 + n), 32'd64);
        wait_idle();
        probe(6'd3);
        check("prio_write_dropped_a", 32'(rd_char_a), 32'd0);
        check("prio_fill_b", 32'(rd_char_b), 32'h20);

        // Reset asserted partway through a scroll.
        for (int i = 0; i < 20; i++) send(1'b1, 8'(8'h61 + i), '0);
        cmd_scroll = 1'b1;
        step();
        cmd_scroll = 1'b0;
        for (int i = 0; i < 20; i++) step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        do_reset();
        wait_idle();
        for (int a = 0; a < 64; a++) begin
            probe(AW'(a));
            check("rst_mid_cell_a", 32'(rd_char_a), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            cmd_clear  = ($urandom_range(0, 299) == 0);
            cmd_scroll = ($urandom_range(0, 149) == 0);
            wr_valid   = ($urandom_range(0, 9) < 7);
            wr_mode    = ($urandom_range(0, 3) != 0);
            wr_index   = AW'($urandom_range(0, 63));
            rd_addr    = AW'($urandom_range(0, 63));
            r = $urandom_range(0, 19);
            wr_char    = (r == 0) ? 8'h0A : (r == 1) ? 8'h0D : 8'($urandom_range(8'h20, 8'h7E));
            step();
        end
        cmd_clear  = 1'b0;
        cmd_scroll = 1'b0;
        wr_valid   = 1'b0;
        wait_idle();
        for (int a = 0; a < 64; a++) probe(AW'(a));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
